dmem_arbiter: RTL

Two-port arbiter and access sequencer in front of the word-organised big-endian data memory (`dataMEM`). Port 0 serves the pipeline MEM stage and port 1 serves the program/data loader. The block grants one requester at a time with round-robin fairness and issues word reads and writes directly. Byte and halfword stores are turned into a read-modify-write sequence over two cycles.

---
 rtl/dmem_arbiter_pkg.sv | 41 ++++
 rtl/dmem_arbiter_lane_merge.sv | 40 ++++
 rtl/dmem_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types, encodings and helpers for the data-memory arbiter.
package dmem_arbiter_pkg;

   localparam int unsigned WORD_LEN = 32;

   // Access size encodings
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_MERGE = 1'b1
   } arb_state_t;

   // Request payload presented by a port
   typedef struct packed {
      logic                we;
      logic [1:0]          size;
      logic [WORD_LEN-1:0] addr;
      logic [WORD_LEN-1:0] wdata;
   } mem_req_t;

   // Misaligned half/word or an illegal size encoding
   function automatic logic access_err(input logic [1:0] size, input logic [1:0] offset);
      logic err;
      case (size)
         SIZE_BYTE: err = 1'b0;
         SIZE_HALF: err = offset[0];
         SIZE_WORD: err = (offset != 2'b00);
         default:   err = 1'b1;
      endcase
      return err;
   endfunction

   // Word-aligned memory address
   function automatic logic [WORD_LEN-1:0] word_align(input logic [WORD_LEN-1:0] addr);
      return {addr[WORD_LEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/dmem_arbiter_lane_merge.sv
// Big-endian lane insert (store merge) and extract (load) for byte/half/word.
module lane_merge
   import dmem_arbiter_pkg::*;
(
   input  logic [WORD_LEN-1:0] old_word,
   input  logic [WORD_LEN-1:0] new_data,
   input  logic [1:0]          offset,
   input  logic [1:0]          size,
   output logic [WORD_LEN-1:0] merged,
   output logic [WORD_LEN-1:0] extracted
);

   logic [4:0] shamt;

   // Byte offset k sits (3-k) bytes up from bit 0; a half at k sits (2-k) bytes up
   always_comb begin
      shamt     = 5'd0;
      merged    = new_data;
      extracted = old_word;
      case (size)
         SIZE_BYTE: begin
            shamt     = {~offset, 3'b000};
            merged    = (old_word & ~(WORD_LEN'(8'hFF) << shamt))
                      | (WORD_LEN'(new_data[7:0]) << shamt);
            extracted = (old_word >> shamt) & WORD_LEN'(8'hFF);
         end
         SIZE_HALF: begin
            shamt     = {~offset[1], 4'b0000};
            merged    = (old_word & ~(WORD_LEN'(16'hFFFF) << shamt))
                      | (WORD_LEN'(new_data[15:0]) << shamt);
            extracted = (old_word >> shamt) & WORD_LEN'(16'hFFFF);
         end
         default: begin
            merged    = new_data;
            extracted = old_word;
         end
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the big-endian data memory.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
(
   input  logic                clk,
   input  logic                rst,

   input  logic                p0_req,
   input  logic                p0_we,
   input  logic [1:0]          p0_size,
   input  logic [WORD_LEN-1:0] p0_addr,
   input  logic [WORD_LEN-1:0] p0_wdata,
   output logic                p0_ack,
   output logic                p0_err,
   output logic [WORD_LEN-1:0] p0_rdata,

   input  logic                p1_req,
   input  logic                p1_we,
   input  logic [1:0]          p1_size,
   input  logic [WORD_LEN-1:0] p1_addr,
   input  logic [WORD_LEN-1:0] p1_wdata,
   output logic                p1_ack,
   output logic                p1_err,
   output logic [WORD_LEN-1:0] p1_rdata,

   output logic                mem_readEN,
   output logic                mem_writeEN,
   output logic [WORD_LEN-1:0] mem_address,
   output logic [WORD_LEN-1:0] mem_dataIn,
   input  logic [WORD_LEN-1:0] mem_dataOut,

   output logic                busy
);

   arb_state_t          state;
   logic                last;

   // Context captured for the write half of a read-modify-write
   logic                lat_port;
   logic [WORD_LEN-1:0] lat_addr;
   logic [1:0]          lat_size;
   logic [WORD_LEN-1:0] lat_wdata;
   logic [WORD_LEN-1:0] lat_word;

   logic                elig0;
   logic                elig1;
   logic                grant_valid;
   logic                grant_port;
   logic                grant_err;
   logic                grant_rmw;
   mem_req_t            cur_req;

   logic [WORD_LEN-1:0] lm_old;
   logic [WORD_LEN-1:0] lm_new;
   logic [1:0]          lm_off;
   logic [1:0]          lm_size;
   logic [WORD_LEN-1:0] lm_merged;
   logic [WORD_LEN-1:0] lm_extracted;

   // Eligibility and round-robin pick; an acked request cannot be re-granted the same cycle
   always_comb begin
      elig0       = p0_req & ~p0_ack;
      elig1       = p1_req & ~p1_ack;
      grant_valid = (state == ARB_IDLE) && !rst && (elig0 || elig1);
      grant_port  = (elig0 && elig1) ? ~last : elig1;
      if (grant_port) begin
         cur_req.we    = p1_we;
         cur_req.size  = p1_size;
         cur_req.addr  = p1_addr;
         cur_req.wdata = p1_wdata;
      end else begin
         cur_req.we    = p0_we;
         cur_req.size  = p0_size;
         cur_req.addr  = p0_addr;
         cur_req.wdata = p0_wdata;
      end
      grant_err = access_err(cur_req.size, cur_req.addr[1:0]);
      grant_rmw = cur_req.we && (cur_req.size != SIZE_WORD);
   end

   // One lane unit serves load extraction in IDLE and the store merge in MERGE
   always_comb begin
      if (state == ARB_MERGE) begin
         lm_old  = lat_word;
         lm_off  = lat_addr[1:0];
         lm_size = lat_size;
      end else begin
         lm_old  = mem_dataOut;
         lm_off  = cur_req.addr[1:0];
         lm_size = cur_req.size;
      end
      lm_new = lat_wdata;
   end

   lane_merge u_lane_merge (
      .old_word  (lm_old),
      .new_data  (lm_new),
      .offset    (lm_off),
      .size      (lm_size),
      .merged    (lm_merged),
      .extracted (lm_extracted)
   );

   // Memory strobes follow the grant in the same cycle; everything is zero when idle or in reset
   always_comb begin
      mem_readEN  = 1'b0;
      mem_writeEN = 1'b0;
      mem_address = '0;
      mem_dataIn  = '0;
      if (!rst && state == ARB_MERGE) begin
         mem_writeEN = 1'b1;
         mem_address = word_align(lat_addr);
         mem_dataIn  = lm_merged;
      end else if (grant_valid && !grant_err) begin
         mem_address = word_align(cur_req.addr);
         if (cur_req.we && cur_req.size == SIZE_WORD) begin
            mem_writeEN = 1'b1;
            mem_dataIn  = cur_req.wdata;
         end else begin
            mem_readEN = 1'b1;
         end
      end
   end

   // Sequencer state, round-robin pointer and registered ack/err/rdata
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARB_IDLE;
         last      <= 1'b1;
         p0_ack    <= 1'b0;
         p0_err    <= 1'b0;
         p0_rdata  <= '0;
         p1_ack    <= 1'b0;
         p1_err    <= 1'b0;
         p1_rdata  <= '0;
         lat_port  <= 1'b0;
         lat_addr  <= '0;
         lat_size  <= SIZE_BYTE;
         lat_wdata <= '0;
         lat_word  <= '0;
      end else begin
         p0_ack   <= 1'b0;
         p0_err   <= 1'b0;
         p0_rdata <= '0;
         p1_ack   <= 1'b0;
         p1_err   <= 1'b0;
         p1_rdata <= '0;
         case (state)
            ARB_IDLE: begin
               if (grant_valid) begin
                  last <= grant_port;
                  if (grant_err) begin
                     if (grant_port) begin
                        p1_ack <= 1'b1;
                        p1_err <= 1'b1;
                     end else begin
                        p0_ack <= 1'b1;
                        p0_err <= 1'b1;
                     end
                  end else if (grant_rmw) begin
                     lat_port  <= grant_port;
                     lat_addr  <= cur_req.addr;
                     lat_size  <= cur_req.size;
                     lat_wdata <= cur_req.wdata;
                     lat_word  <= mem_dataOut;
                     state     <= ARB_MERGE;
                  end else if (grant_port) begin
                     p1_ack   <= 1'b1;
                     p1_rdata <= cur_req.we ? '0 : lm_extracted;
                  end else begin
                     p0_ack   <= 1'b1;
                     p0_rdata <= cur_req.we ? '0 : lm_extracted;
                  end
               end
            end
            ARB_MERGE: begin
               if (lat_port) p1_ack <= 1'b1;
               else          p0_ack <= 1'b1;
               state <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign busy = (state != ARB_IDLE);

endmodule
